// File: rtl/ipsxe_floating_point_pkg.sv
// Shared floating-point definitions for the unpack front-end and the round/pack stage.
// The class-flag ordering {nan, inf, denorm, zero} is common to both ends of the FMA.
package ipsxe_floating_point_pkg;

  localparam int unsigned SP_EXP_WIDTH = 8;
  localparam int unsigned SP_MAN_WIDTH = 23;
  localparam int unsigned BIAS         = 2 ** (SP_EXP_WIDTH - 1) - 1;

  localparam logic [SP_EXP_WIDTH-1:0] EXP_ALL_ONES = '1;

  typedef struct packed {
    logic nan;
    logic inf;
    logic denorm;
    logic zero;
  } fp_class_t;

  // Unbiased exponent of a single-precision exponent field (for debug and models).
  function automatic int unbiased_exp(logic [SP_EXP_WIDTH-1:0] exp_field);
    return int'(exp_field) - int'(BIAS);
  endfunction

  function automatic logic exp_is_all_ones(logic [SP_EXP_WIDTH-1:0] exp_field);
    return exp_field == EXP_ALL_ONES;
  endfunction

endpackage

// File: rtl/ipsxe_floating_point_unpack_single_v1_0_if.sv
// Operand-in / unpacked-result-out stream bundle for the single-precision unpack stage.
// The slave modport is the unpacker itself; the master modport is its environment.
interface ipsxe_floating_point_unpack_single_v1_0_if #(
  parameter int unsigned EXP_WIDTH = 8,
  parameter int unsigned MAN_WIDTH = 23,
  parameter int unsigned W_USER    = 1
);

  logic                         i_aclken;
  logic                         i_valid;
  logic                         o_ready;
  logic [EXP_WIDTH+MAN_WIDTH:0] i_float;
  logic [W_USER-1:0]            i_user;

  logic                         o_valid;
  logic                         i_ready;
  logic                         o_sign;
  logic [EXP_WIDTH+1:0]         o_exp;
  logic [MAN_WIDTH:0]           o_man;
  logic                         o_is_zero;
  logic                         o_is_inf;
  logic                         o_is_nan;
  logic                         o_is_denorm;
  logic [W_USER-1:0]            o_user;

  modport slave (
    input  i_aclken,
    input  i_valid,
    output o_ready,
    input  i_float,
    input  i_user,
    output o_valid,
    input  i_ready,
    output o_sign,
    output o_exp,
    output o_man,
    output o_is_zero,
    output o_is_inf,
    output o_is_nan,
    output o_is_denorm,
    output o_user
  );

  modport master (
    output i_aclken,
    output i_valid,
    input  o_ready,
    output i_float,
    output i_user,
    input  o_valid,
    output i_ready,
    input  o_sign,
    input  o_exp,
    input  o_man,
    input  o_is_zero,
    input  o_is_inf,
    input  o_is_nan,
    input  o_is_denorm,
    input  o_user
  );

endinterface

// File: rtl/ipsxe_floating_point_lzc_man_v1_0.sv
// Combinational leading-zero count of a stored mantissa field.
// An all-zero field returns MAN_WIDTH.
module ipsxe_floating_point_lzc_man_v1_0 #(
  parameter int unsigned MAN_WIDTH     = 23,
  parameter int unsigned LEADING_0_CNT = 5
) (
  input  logic [MAN_WIDTH-1:0]     man,
  output logic [LEADING_0_CNT-1:0] lz
);

  // Scan upward so the highest set bit is the last one to write the result.
  always_comb begin
    lz = LEADING_0_CNT'(MAN_WIDTH);
    for (int i = 0; i < int'(MAN_WIDTH); i++) begin
      if (man[i]) begin
        lz = LEADING_0_CNT'(int'(MAN_WIDTH) - 1 - i);
      end
    end
  end

endmodule

// File: rtl/ipsxe_floating_point_unpack_single_v1_0.sv
// Two-stage unpack of a packed IEEE-754 operand into sign / extended exponent / explicit mantissa.
// Define IPSXE_FP_UNPACK_DENORM_EN to normalise denormals; otherwise they are flushed to zero.
module ipsxe_floating_point_unpack_single_v1_0
  import ipsxe_floating_point_pkg::*;
#(
  parameter int unsigned EXP_WIDTH     = SP_EXP_WIDTH,
  parameter int unsigned MAN_WIDTH     = SP_MAN_WIDTH,
  parameter int unsigned LEADING_0_CNT = 5,
  parameter int unsigned W_USER        = 1
) (
  input logic                                    i_clk,
  input logic                                    i_rst,
  ipsxe_floating_point_unpack_single_v1_0_if.slave bus
);

  if (LEADING_0_CNT < $clog2(MAN_WIDTH + 1)) begin : g_lz_width_check
    $error("LEADING_0_CNT is too narrow for MAN_WIDTH");
  end

  // Input field split and classification
  logic [EXP_WIDTH-1:0] in_exp;
  logic [MAN_WIDTH-1:0] in_man;
  logic                 in_exp_max;
  logic                 in_exp_zero;
  logic                 in_man_zero;
  fp_class_t            in_class;

  assign in_exp      = bus.i_float[EXP_WIDTH+MAN_WIDTH-1:MAN_WIDTH];
  assign in_man      = bus.i_float[MAN_WIDTH-1:0];
  assign in_exp_max  = &in_exp;
  assign in_exp_zero = (in_exp == '0);
  assign in_man_zero = (in_man == '0);

  always_comb begin
    in_class        = '0;
    in_class.nan    = in_exp_max && !in_man_zero;
    in_class.inf    = in_exp_max && in_man_zero;
    in_class.denorm = in_exp_zero && !in_man_zero;
`ifdef IPSXE_FP_UNPACK_DENORM_EN
    in_class.zero   = in_exp_zero && in_man_zero;
`else
    // Flushed denormals report as zero while still flagging the original class.
    in_class.zero   = in_exp_zero;
`endif
  end

`ifdef IPSXE_FP_UNPACK_DENORM_EN
  logic [LEADING_0_CNT-1:0] in_lz;

  ipsxe_floating_point_lzc_man_v1_0 #(
    .MAN_WIDTH     (MAN_WIDTH),
    .LEADING_0_CNT (LEADING_0_CNT)
  ) u_lzc (
    .man (in_man),
    .lz  (in_lz)
  );
`endif

  // Pipeline control
  logic s1_valid;
  logic s2_valid;
  logic s1_advance;
  logic s1_load;
  logic s2_load;

  assign s1_advance  = !s2_valid || bus.i_ready;
  assign s1_load     = bus.i_aclken && (!s1_valid || s1_advance);
  assign s2_load     = bus.i_aclken && s1_advance;
  assign bus.o_ready = s1_load;

  // Stage 1: classify and capture raw fields
  logic                 s1_sign;
  fp_class_t            s1_class;
  logic [EXP_WIDTH-1:0] s1_exp;
  logic [MAN_WIDTH-1:0] s1_man;
  logic [W_USER-1:0]    s1_user;
`ifdef IPSXE_FP_UNPACK_DENORM_EN
  logic [LEADING_0_CNT-1:0] s1_lz;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_class <= '0;
      s1_exp   <= '0;
      s1_man   <= '0;
      s1_user  <= '0;
`ifdef IPSXE_FP_UNPACK_DENORM_EN
      s1_lz    <= '0;
`endif
    end else if (s1_load) begin
      s1_valid <= bus.i_valid;
      if (bus.i_valid) begin
        s1_sign  <= bus.i_float[EXP_WIDTH+MAN_WIDTH];
        s1_class <= in_class;
        s1_exp   <= in_exp;
        s1_man   <= in_man;
        s1_user  <= bus.i_user;
`ifdef IPSXE_FP_UNPACK_DENORM_EN
        s1_lz    <= in_lz;
`endif
      end
    end
  end

  // Stage 2: normalise
  logic [EXP_WIDTH+1:0] norm_exp;
  logic [MAN_WIDTH:0]   norm_man;

  always_comb begin
    norm_exp = '0;
    norm_man = '0;
    if (s1_class.nan) begin
      // Keep the quiet bit so downstream can tell qNaN from sNaN.
      norm_man[MAN_WIDTH-1] = s1_man[MAN_WIDTH-1];
    end else if (s1_class.denorm) begin
`ifdef IPSXE_FP_UNPACK_DENORM_EN
      // Value m*2^(1-bias-MAN_WIDTH) re-expressed with a leading 1: exponent 1-(lz+1).
      norm_man = {s1_man, 1'b0} << s1_lz;
      norm_exp = -((EXP_WIDTH + 2)'(s1_lz));
`endif
    end else if (!s1_class.zero && !s1_class.inf) begin
      norm_exp = {2'b00, s1_exp};
      norm_man = {1'b1, s1_man};
    end
  end

  logic                 s2_sign;
  logic [EXP_WIDTH+1:0] s2_exp;
  logic [MAN_WIDTH:0]   s2_man;
  fp_class_t            s2_class;
  logic [W_USER-1:0]    s2_user;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_exp   <= '0;
      s2_man   <= '0;
      s2_class <= '0;
      s2_user  <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sign  <= s1_sign;
        s2_exp   <= norm_exp;
        s2_man   <= norm_man;
        s2_class <= s1_class;
        s2_user  <= s1_user;
      end
    end
  end

  assign bus.o_valid     = s2_valid;
  assign bus.o_sign      = s2_sign;
  assign bus.o_exp       = s2_exp;
  assign bus.o_man       = s2_man;
  assign bus.o_is_zero   = s2_class.zero;
  assign bus.o_is_inf    = s2_class.inf;
  assign bus.o_is_nan    = s2_class.nan;
  assign bus.o_is_denorm = s2_class.denorm;
  assign bus.o_user      = s2_user;

endmodule
